// File: rtl/csr_pkg.sv
// Shared constants, mstatus field layout and FSM encoding for the machine-mode
// trap/return sequencer.
package csr_pkg;

  localparam logic [11:0] CSR_ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_ADDR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_ADDR_MTVAL   = 12'h343;

  localparam logic [31:0] CSR_IRQ_CAUSE = 32'h8000_000B;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam logic [31:0] TRAP_MSTATUS_MASK = 32'h0000_1888;
  localparam logic [31:0] FULL_MASK         = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MTVAL,
    S_W_MSTATUS,
    S_RET_MSTATUS,
    S_REDIRECT
  } state_e;

  // mstatus value written on trap entry: MPIE <= old MIE, MIE <= 0, MPP <= M.
  function automatic logic [31:0] trap_mstatus(input logic old_mie);
    logic [31:0] d;
    d = '0;
    d[MSTATUS_MPIE] = old_mie;
    d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return d;
  endfunction

  // mstatus value written on MRET: MIE <= MPIE, MPIE <= 1, MPP <= M.
  function automatic logic [31:0] ret_mstatus(input logic old_mpie);
    logic [31:0] d;
    d = '0;
    d[MSTATUS_MIE]  = old_mpie;
    d[MSTATUS_MPIE] = 1'b1;
    d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return d;
  endfunction

endpackage

// File: rtl/csr_trap_target.sv
// Redirect target selection: MRET returns to mepc, traps go to mtvec base,
// interrupts optionally offset by cause*4 in vectored mode.
module csr_trap_target #(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        is_ret,
  input  logic        is_irq,
  input  logic [4:0]  cause_lo,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [31:0] target
);

  logic [31:0] base;
  logic        unused_ok;

  assign base      = {mtvec[31:2], 2'b00};
  assign unused_ok = ^mepc[1:0];

  always_comb begin
    if (is_ret) begin
      target = {mepc[31:2], 2'b00};
    end else if (VECTORED_EN && is_irq && (mtvec[1:0] == 2'b01)) begin
      target = base + {25'd0, cause_lo, 2'b00};
    end else begin
      target = base;
    end
  end

endmodule

// File: rtl/csr_trap_sequencer.sv
// WB-boundary trap/MRET controller: detects, flushes, serialises the trap CSR
// updates through the shared CSR write port, then strobes a PC redirect.
module csr_trap_sequencer
  import csr_pkg::*;
#(
  parameter logic [11:0] ADDR_MSTATUS = CSR_ADDR_MSTATUS,
  parameter logic [11:0] ADDR_MEPC    = CSR_ADDR_MEPC,
  parameter logic [11:0] ADDR_MCAUSE  = CSR_ADDR_MCAUSE,
  parameter logic [11:0] ADDR_MTVAL   = CSR_ADDR_MTVAL,
  parameter logic [31:0] IRQ_CAUSE    = CSR_IRQ_CAUSE,
  parameter bit          VECTORED_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid_i,
  input  logic        wb_exception_i,
  input  logic [31:0] wb_cause_i,
  input  logic [31:0] wb_tval_i,
  input  logic [31:0] wb_pc_i,
  input  logic        wb_mret_i,
  input  logic        irq_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic        pipe_wen_i,
  input  logic [11:0] pipe_waddr_i,
  input  logic [31:0] pipe_wdata_i,
  input  logic [31:0] pipe_wmask_i,
  output logic        csr_wen_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic [31:0] csr_wmask_o,
  output logic        wb_kill_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, cause_q, tval_q;
  logic        is_irq_q, is_ret_q;
  logic        take_exc, take_irq, take_ret;
  logic [31:0] target;
  logic        unused_ok;

  assign unused_ok = ^{pc_q[1:0], mstatus_i[31:8], mstatus_i[6:4], mstatus_i[2:0]};

  csr_trap_target #(
    .VECTORED_EN (VECTORED_EN)
  ) u_target (
    .is_ret   (is_ret_q),
    .is_irq   (is_irq_q),
    .cause_lo (cause_q[4:0]),
    .mtvec    (mtvec_i),
    .mepc     (mepc_i),
    .target   (target)
  );

  // NOTE: every output and next-state term gets a default before the case,
  // so no path through this block can infer a latch.
  always_comb begin
    state_d          = state_q;
    take_exc         = 1'b0;
    take_irq         = 1'b0;
    take_ret         = 1'b0;
    csr_wen_o        = 1'b0;
    csr_waddr_o      = '0;
    csr_wdata_o      = '0;
    csr_wmask_o      = '0;
    wb_kill_o        = 1'b0;
    flush_o          = 1'b0;
    stall_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;

    if (!rst) begin
      stall_o = (state_q != S_IDLE);
      unique case (state_q)
        S_IDLE: begin
          take_exc = wb_valid_i && wb_exception_i;
          take_irq = wb_valid_i && !take_exc && irq_i && mstatus_i[MSTATUS_MIE];
          take_ret = wb_valid_i && !take_exc && !take_irq && wb_mret_i;
          if (take_exc || take_irq) begin
            flush_o   = 1'b1;
            wb_kill_o = 1'b1;
            state_d   = S_W_MEPC;
          end else begin
            // MRET retires normally, so its own pipelined write still lands.
            if (take_ret) begin
              flush_o = 1'b1;
              state_d = S_RET_MSTATUS;
            end
            if (pipe_wen_i) begin
              csr_wen_o   = 1'b1;
              csr_waddr_o = pipe_waddr_i;
              csr_wdata_o = pipe_wdata_i;
              csr_wmask_o = pipe_wmask_i;
            end
          end
        end
        S_W_MEPC: begin
          csr_wen_o   = 1'b1;
          csr_waddr_o = ADDR_MEPC;
          csr_wdata_o = {pc_q[31:2], 2'b00};
          csr_wmask_o = FULL_MASK;
          state_d     = S_W_MCAUSE;
        end
        S_W_MCAUSE: begin
          csr_wen_o   = 1'b1;
          csr_waddr_o = ADDR_MCAUSE;
          csr_wdata_o = cause_q;
          csr_wmask_o = FULL_MASK;
          state_d     = S_W_MTVAL;
        end
        S_W_MTVAL: begin
          csr_wen_o   = 1'b1;
          csr_waddr_o = ADDR_MTVAL;
          csr_wdata_o = tval_q;
          csr_wmask_o = FULL_MASK;
          state_d     = S_W_MSTATUS;
        end
        S_W_MSTATUS: begin
          csr_wen_o   = 1'b1;
          csr_waddr_o = ADDR_MSTATUS;
          csr_wdata_o = trap_mstatus(mstatus_i[MSTATUS_MIE]);
          csr_wmask_o = TRAP_MSTATUS_MASK;
          state_d     = S_REDIRECT;
        end
        S_RET_MSTATUS: begin
          csr_wen_o   = 1'b1;
          csr_waddr_o = ADDR_MSTATUS;
          csr_wdata_o = ret_mstatus(mstatus_i[MSTATUS_MPIE]);
          csr_wmask_o = TRAP_MSTATUS_MASK;
          state_d     = S_REDIRECT;
        end
        S_REDIRECT: begin
          redirect_valid_o = 1'b1;
          redirect_pc_o    = target;
          state_d          = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      is_irq_q <= 1'b0;
      is_ret_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_exc || take_irq || take_ret) begin
        pc_q     <= wb_pc_i;
        cause_q  <= take_irq ? IRQ_CAUSE : wb_cause_i;
        tval_q   <= take_irq ? 32'd0 : wb_tval_i;
        is_irq_q <= take_irq;
        is_ret_q <= take_ret;
      end
    end
  end

endmodule
